// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion controller: builds all 44 schedule words into an internal buffer
// and serves round keys combinationally. Define AES_KS_FAST_SUB_EN for a 4-S-box, 1-cycle SubWord.
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_XOR} state_t;

  localparam logic [255:0][7:0] SBOX_TBL = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // First table entry sits at index 255, so the lookup index is 255-x, i.e. ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t      state, state_nxt;
  logic [1:0]  step;
  logic [5:0]  widx;
  logic [7:0]  rcon;
  logic [31:0] temp;
  logic [31:0] w_buf [44];

  logic        load_key, sub_en, xor_en, fin;
  logic [5:0]  idx_m1, idx_m4, rk_base;
  logic [31:0] prev_w, xor_rhs;

  assign idx_m1 = widx - 6'd1;
  assign idx_m4 = widx - 6'd4;
  assign prev_w = w_buf[idx_m1];
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    load_key  = 1'b0;
    sub_en    = 1'b0;
    xor_en    = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_key  = 1'b1;
          state_nxt = ST_SUB;
        end
      end
      ST_SUB: begin
        sub_en = 1'b1;
`ifdef AES_KS_FAST_SUB_EN
        state_nxt = ST_XOR;
`else
        if (step == 2'd3) state_nxt = ST_XOR;
`endif
      end
      ST_XOR: begin
        xor_en = 1'b1;
        if (step == 2'd3) begin
          // widx still names the word being written this cycle
          if (widx == 6'd43) begin
            fin       = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_SUB;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step      <= 2'd0;
      widx      <= 6'd0;
      rcon      <= 8'h01;
      done      <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= fin;
      if (load_key) begin
        widx      <= 6'd4;
        rcon      <= 8'h01;
        step      <= 2'd0;
        key_valid <= 1'b0;
      end
`ifndef AES_KS_FAST_SUB_EN
      if (sub_en) step <= step + 2'd1;
`endif
      if (xor_en) begin
        widx <= widx + 6'd1;
        step <= step + 2'd1;
        if (step == 2'd0) rcon <= xtime(rcon);
      end
      if (fin) key_valid <= 1'b1;
    end
  end

`ifdef AES_KS_FAST_SUB_EN
  logic [31:0] sub_word;

  assign sub_word = {sbox(prev_w[23:16]), sbox(prev_w[15:8]),
                     sbox(prev_w[7:0]),   sbox(prev_w[31:24])};
`else
  logic [1:0] sub_sel;
  logic [7:0] sub_byte;

  // Byte (k+1) mod 4 of w[i-1]; shifting results in from the right yields RotWord order.
  assign sub_sel = step + 2'd1;

  always_comb begin
    sub_byte = prev_w[31:24];
    case (sub_sel)
      2'd0: sub_byte = prev_w[31:24];
      2'd1: sub_byte = prev_w[23:16];
      2'd2: sub_byte = prev_w[15:8];
      2'd3: sub_byte = prev_w[7:0];
      default: sub_byte = prev_w[31:24];
    endcase
  end
`endif

  assign xor_rhs = (step == 2'd0) ? (temp ^ {rcon, 24'h0}) : prev_w;

  always_ff @(posedge clk) begin
    if (load_key) begin
      w_buf[0] <= key[127:96];
      w_buf[1] <= key[95:64];
      w_buf[2] <= key[63:32];
      w_buf[3] <= key[31:0];
    end
    if (sub_en) begin
`ifdef AES_KS_FAST_SUB_EN
      temp <= sub_word;
`else
      temp <= {temp[23:0], sbox(sub_byte)};
`endif
    end
    if (xor_en) w_buf[widx] <= w_buf[idx_m4] ^ xor_rhs;
  end

  assign rk_base = {rk_idx, 2'b00};

  always_comb begin
    rk_out = 128'h0;
    if (rk_idx <= 4'd10)
      rk_out = {w_buf[rk_base], w_buf[rk_base + 6'd1],
                w_buf[rk_base + 6'd2], w_buf[rk_base + 6'd3]};
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: stimulus queues expected completions,
// a monitor checks each done pulse for latency, flags and round-key contents.
module tb_aes_key_sched_ctrl;

`ifdef AES_KS_FAST_SUB_EN
  localparam int LAT = 50;
`else
  localparam int LAT = 80;
`endif

  typedef struct {
    int           acc;
    int           n;
    logic [3:0]   idx [8];
    logic [127:0] val [8];
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy, done, key_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  aes_key_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out)
  );

  always #10 clk = ~clk;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: owns rk_idx, pops one expectation per done pulse.
  exp_t me;
  int   bcnt = 0;
  logic prev_done = 1'b0;
  logic prev_kv = 1'b0;

  initial rk_idx = 4'd0;

  always @(negedge clk) begin
    if (prev_done) chk("done_width", 128'(done), 128'd0);
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 128'(done), 128'd0);
      end else begin
        me = q.pop_front();
        chk("done_latency", 128'(cyc), 128'(me.acc + LAT));
        chk("busy_cycles", 128'(bcnt), 128'(LAT));
        chk("busy_at_done", 128'(busy), 128'd0);
        chk("kv_at_done", 128'(key_valid), 128'd1);
        chk("kv_before_done", 128'(prev_kv), 128'd0);
        for (int k = 0; k < me.n; k++) begin
          rk_idx = me.idx[k];
          #1;
          chk($sformatf("rk_out[%0d]", me.idx[k]), rk_out, me.val[k]);
        end
      end
      bcnt = 0;
    end else if (busy === 1'b1) begin
      bcnt++;
    end else begin
      bcnt = 0;
    end
    prev_done = (done === 1'b1);
    prev_kv   = key_valid;
  end

  task automatic issue(input logic [127:0] k, input bit track, input exp_t e_in, output int acc);
    exp_t e;
    key   = k;
    start = 1'b1;
    acc   = cyc + 1;
    e     = e_in;
    e.acc = acc;
    if (track) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({nm, "_timeout"}, 128'd0, 128'd1);
  endtask

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  exp_t e_fips, e_seq, e_zero, e_none;
  int   acc;

  initial begin
    e_fips.acc = 0; e_fips.n = 4;
    e_fips.idx[0] = 4'd0;  e_fips.val[0] = K_FIPS;
    e_fips.idx[1] = 4'd1;  e_fips.val[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    e_fips.idx[2] = 4'd2;  e_fips.val[2] = 128'hf2c295f27a96b9435935807a7359f67f;
    e_fips.idx[3] = 4'd10; e_fips.val[3] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    e_seq.acc = 0; e_seq.n = 8;
    e_seq.idx[0] = 4'd0;  e_seq.val[0] = K_SEQ;
    e_seq.idx[1] = 4'd1;  e_seq.val[1] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    e_seq.idx[2] = 4'd10; e_seq.val[2] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int k = 3; k < 8; k++) begin
      e_seq.idx[k] = 4'(k + 8);
      e_seq.val[k] = 128'h0;
    end

    e_zero.acc = 0; e_zero.n = 3;
    e_zero.idx[0] = 4'd0; e_zero.val[0] = 128'h0;
    e_zero.idx[1] = 4'd1; e_zero.val[1] = 128'h62636363626363636263636362636363;
    e_zero.idx[2] = 4'd2; e_zero.val[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    e_none = e_zero;
    e_none.n = 0;

    rst_n = 1'b0;
    start = 1'b0;
    key   = 128'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_kv", 128'(key_valid), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 key, clean run
    issue(K_FIPS, 1'b1, e_fips, acc);
    wait_done("run_fips");
    repeat (3) @(negedge clk);

    // Same key with start re-pulsed (and a different key presented) while busy
    issue(K_FIPS, 1'b1, e_fips, acc);
    while (cyc < acc + 9) @(negedge clk);
    start = 1'b1; key = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 39) @(negedge clk);
    start = 1'b1; key = 128'h11111111_22222222_33333333_44444444;
    @(negedge clk);
    start = 1'b0;
    wait_done("run_glitch");
    repeat (3) @(negedge clk);

    // Reset for one cycle at cycle 30 of a run; no completion expected
    issue(K_FIPS, 1'b0, e_none, acc);
    chk("kv_cleared_on_start", 128'(key_valid), 128'd0);
    while (cyc < acc + 29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_kv", 128'(key_valid), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    repeat (5) @(negedge clk);
    chk("midrst_idle", 128'(busy), 128'd0);

    // Fresh start after reset, then back-to-back restart in its done cycle
    issue(K_SEQ, 1'b1, e_seq, acc);
    wait_done("run_seq");
    issue(128'h0, 1'b1, e_zero, acc);
    chk("kv_drop_b2b", 128'(key_valid), 128'd0);
    chk("busy_b2b", 128'(busy), 128'd1);
    wait_done("run_zero");
    repeat (3) @(negedge clk);

    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
